// File: rtl/microwave_pkg.sv
// Shared key codes, BCD digit type and controller state encoding for the
// microwave timer keypad loader.
package microwave_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_START = 4'hB;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } tel_state_t;

  // Saturating increment keeps a digit inside the BCD range.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= BCD_MAX) ? BCD_MAX : d + 4'd1;
  endfunction

endpackage

// File: rtl/digit_entry_shifter.sv
// Three-digit M:SS BCD entry register: shift-in, clear, validate and normalise.
// AUTO_NORMALIZE_EN: when defined, an over-range seconds-tens digit is folded into minutes.
module digit_entry_shifter
  import microwave_pkg::*;
#(
  parameter int MAX_SEC_TENS = 5
) (
  input  logic clk,
  input  logic clrn,
  input  logic i_shift,
  input  bcd_t i_digit,
  input  logic i_clear,
  input  logic i_normalize,
  output bcd_t o_min,
  output bcd_t o_sec_tens,
  output bcd_t o_sec_ones,
  output logic o_entry_ok,
  output logic o_needs_norm
);

  localparam bcd_t TENS_LIMIT = bcd_t'(MAX_SEC_TENS);
  localparam bcd_t TENS_WRAP  = bcd_t'(MAX_SEC_TENS + 1);

  bcd_t r_min;
  bcd_t r_sec_tens;
  bcd_t r_sec_ones;
  logic w_all_zero;
  logic w_tens_over;

  always_comb begin
    w_all_zero  = (r_min == '0) && (r_sec_tens == '0) && (r_sec_ones == '0);
    w_tens_over = (r_sec_tens > TENS_LIMIT);
`ifdef AUTO_NORMALIZE_EN
    // Folding needs a free minute; 9 minutes plus carry cannot be shown.
    o_needs_norm = w_tens_over;
    o_entry_ok   = !w_all_zero && (!w_tens_over || (r_min < BCD_MAX));
`else
    o_needs_norm = 1'b0;
    o_entry_ok   = !w_all_zero && !w_tens_over;
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_min      <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
    end else if (i_clear) begin
      r_min      <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
    end else if (i_normalize) begin
      r_min      <= bcd_inc(r_min);
      r_sec_tens <= r_sec_tens - TENS_WRAP;
    end else if (i_shift) begin
      r_min      <= r_sec_tens;
      r_sec_tens <= r_sec_ones;
      r_sec_ones <= (i_digit > BCD_MAX) ? BCD_MAX : i_digit;
    end
  end

  assign o_min      = r_min;
  assign o_sec_tens = r_sec_tens;
  assign o_sec_ones = r_sec_ones;

endmodule

// File: rtl/time_entry_loader.sv
// Keypad-side writer for the microwave timer digit chain: entry, validation,
// parallel load and count gating. AUTO_NORMALIZE_EN selects entry normalisation.
//
// state    | meaning
// IDLE     | no entry, digits zero
// ENTRY    | collecting keypad digits
// LOAD     | one-cycle active-low parallel load of the counters
// RUN      | counters enabled until timer_zero
// PAUSE    | door opened or CLEAR while running; counting held
// DONE     | one-cycle completion pulse, digits cleared
module time_entry_loader
  import microwave_pkg::*;
#(
  parameter int MAX_SEC_TENS = 5,
  parameter int KEY_W        = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             i_key_valid,
  input  logic [KEY_W-1:0] i_key_code,
  input  logic             i_door_closed,
  input  logic             i_timer_zero,
  output logic [3:0]       o_sec_ones_data,
  output logic [3:0]       o_sec_tens_data,
  output logic [3:0]       o_min_data,
  output logic             o_loadn,
  output logic             o_count_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_entry_error
);

  localparam logic [KEY_W-1:0] KEY_LAST_DIGIT = KEY_W'(9);
  localparam logic [KEY_W-1:0] KEY_CLR_W      = KEY_W'(KEY_CLEAR);
  localparam logic [KEY_W-1:0] KEY_START_W    = KEY_W'(KEY_START);

  tel_state_t r_state;
  logic       r_loadn;
  logic       r_count_en;
  logic       r_busy;
  logic       r_done;
  logic       r_entry_error;

  logic w_key_digit;
  logic w_key_clear;
  logic w_key_start;
  logic w_in_entry;
  logic w_start_ok;
  logic w_shift;
  logic w_clear;
  logic w_normalize;
  logic w_entry_ok;
  logic w_needs_norm;
  bcd_t w_key_bcd;
  bcd_t w_min;
  bcd_t w_sec_tens;
  bcd_t w_sec_ones;

  always_comb begin
    w_key_bcd   = bcd_t'(i_key_code[3:0]);
    w_key_digit = i_key_valid && (i_key_code <= KEY_LAST_DIGIT);
    w_key_clear = i_key_valid && (i_key_code == KEY_CLR_W);
    w_key_start = i_key_valid && (i_key_code == KEY_START_W);
    w_in_entry  = (r_state == ST_IDLE) || (r_state == ST_ENTRY);
    w_start_ok  = w_in_entry && w_key_start && i_door_closed && w_entry_ok;
    w_shift     = w_in_entry && w_key_digit;
    w_normalize = w_start_ok && w_needs_norm;
    // Digits are zeroed on any CLEAR that leaves an entry or a pause, and on completion.
    w_clear     = ((w_in_entry || (r_state == ST_PAUSE)) && w_key_clear) ||
                  ((r_state == ST_RUN) && i_timer_zero);
  end

  digit_entry_shifter #(
    .MAX_SEC_TENS (MAX_SEC_TENS)
  ) u_shifter (
    .clk          (clk),
    .clrn         (clrn),
    .i_shift      (w_shift),
    .i_digit      (w_key_bcd),
    .i_clear      (w_clear),
    .i_normalize  (w_normalize),
    .o_min        (w_min),
    .o_sec_tens   (w_sec_tens),
    .o_sec_ones   (w_sec_ones),
    .o_entry_ok   (w_entry_ok),
    .o_needs_norm (w_needs_norm)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state       <= ST_IDLE;
      r_loadn       <= 1'b1;
      r_count_en    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_entry_error <= 1'b0;
    end else begin
      r_loadn       <= 1'b1;
      r_done        <= 1'b0;
      r_entry_error <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ENTRY: begin
          if (w_key_digit) begin
            r_state <= ST_ENTRY;
          end else if (w_key_clear) begin
            r_state <= ST_IDLE;
          end else if (w_key_start) begin
            if (w_start_ok) begin
              r_state <= ST_LOAD;
              r_loadn <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_entry_error <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_state    <= ST_RUN;
          r_count_en <= 1'b1;
        end
        ST_RUN: begin
          // Completion wins over a simultaneous door opening.
          if (i_timer_zero) begin
            r_state    <= ST_DONE;
            r_count_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else if (!i_door_closed || w_key_clear) begin
            r_state    <= ST_PAUSE;
            r_count_en <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (w_key_clear) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_key_start) begin
            if (i_door_closed) begin
              r_state    <= ST_RUN;
              r_count_en <= 1'b1;
            end else begin
              r_entry_error <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_count_en <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_sec_ones_data = w_sec_ones;
  assign o_sec_tens_data = w_sec_tens;
  assign o_min_data      = w_min;
  assign o_loadn         = r_loadn;
  assign o_count_en      = r_count_en;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_entry_error   = r_entry_error;

endmodule

// File: tb/tb_time_entry_loader.sv
// Scoreboard bench for time_entry_loader: directed keypad sequences followed by
// random keys, door and timer_zero activity checked against a behavioural model.
module tb_time_entry_loader;

  localparam int MAXT = 5;
`ifdef AUTO_NORMALIZE_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_LOAD  = 2;
  localparam int M_RUN   = 3;
  localparam int M_PAUSE = 4;
  localparam int M_DONE  = 5;

  logic       clk;
  logic       clrn;
  logic       i_key_valid;
  logic [3:0] i_key_code;
  logic       i_door_closed;
  logic       i_timer_zero;
  logic [3:0] o_sec_ones_data;
  logic [3:0] o_sec_tens_data;
  logic [3:0] o_min_data;
  logic       o_loadn;
  logic       o_count_en;
  logic       o_busy;
  logic       o_done;
  logic       o_entry_error;

  time_entry_loader #(
    .MAX_SEC_TENS (MAXT),
    .KEY_W        (4)
  ) dut (
    .clk             (clk),
    .clrn            (clrn),
    .i_key_valid     (i_key_valid),
    .i_key_code      (i_key_code),
    .i_door_closed   (i_door_closed),
    .i_timer_zero    (i_timer_zero),
    .o_sec_ones_data (o_sec_ones_data),
    .o_sec_tens_data (o_sec_tens_data),
    .o_min_data      (o_min_data),
    .o_loadn         (o_loadn),
    .o_count_en      (o_count_en),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_entry_error   (o_entry_error)
  );

  typedef struct {
    int cyc;
    bit loadn;
    bit cen;
    bit busy;
    bit done;
    bit err;
    int m;
    int t;
    int o;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc;
  int   checks;
  int   errors;
  int   m_mode;
  int   m_min;
  int   m_tens;
  int   m_ones;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: pops the expectation for the edge just taken and compares all outputs.
  always @(negedge clk) begin
    if (clrn && exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (o_loadn !== mon_e.loadn || o_count_en !== mon_e.cen || o_busy !== mon_e.busy ||
          o_done !== mon_e.done || o_entry_error !== mon_e.err ||
          o_min_data !== 4'(mon_e.m) || o_sec_tens_data !== 4'(mon_e.t) ||
          o_sec_ones_data !== 4'(mon_e.o)) begin
        errors++;
        if (errors < 30)
          $display("FAIL cyc %0d got ld=%b ce=%b bz=%b dn=%b er=%b %0d:%0d%0d exp ld=%b ce=%b bz=%b dn=%b er=%b %0d:%0d%0d",
                   cyc, o_loadn, o_count_en, o_busy, o_done, o_entry_error,
                   o_min_data, o_sec_tens_data, o_sec_ones_data,
                   mon_e.loadn, mon_e.cen, mon_e.busy, mon_e.done, mon_e.err,
                   mon_e.m, mon_e.t, mon_e.o);
      end
    end
  end

  task automatic model_reset();
    m_mode = M_IDLE;
    m_min  = 0;
    m_tens = 0;
    m_ones = 0;
  endtask

  task automatic model_zero();
    m_min  = 0;
    m_tens = 0;
    m_ones = 0;
  endtask

  // Behavioural reference: what the controller should look like after one clock.
  task automatic model_step(input bit kv, input int code, input bit door, input bit tz,
                            output bit err);
    bit dig;
    bit clr;
    bit st;
    bit legal;
    dig = kv && (code <= 9);
    clr = kv && (code == 10);
    st  = kv && (code == 11);
    err = 1'b0;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (dig) begin
          m_min  = m_tens;
          m_tens = m_ones;
          m_ones = code;
          m_mode = M_ENTRY;
        end else if (clr) begin
          model_zero();
          m_mode = M_IDLE;
        end else if (st) begin
          legal = (m_min * 60 + m_tens * 10 + m_ones) != 0 &&
                  (m_tens <= MAXT || (NORM && m_min < 9));
          if (door && legal) begin
            if (m_tens > MAXT) begin
              m_tens = m_tens - (MAXT + 1);
              m_min  = m_min + 1;
            end
            m_mode = M_LOAD;
          end else begin
            err = 1'b1;
          end
        end
      end
      M_LOAD: m_mode = M_RUN;
      M_RUN: begin
        if (tz) begin
          model_zero();
          m_mode = M_DONE;
        end else if (!door || clr) begin
          m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (clr) begin
          model_zero();
          m_mode = M_IDLE;
        end else if (st) begin
          if (door) m_mode = M_RUN;
          else      err = 1'b1;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic step(input bit kv, input int code, input bit door, input bit tz);
    exp_t e;
    bit   err;
    @(negedge clk);
    i_key_valid   = kv;
    i_key_code    = 4'(code);
    i_door_closed = door;
    i_timer_zero  = tz;
    model_step(kv, code, door, tz, err);
    e.cyc   = cyc + 1;
    e.loadn = (m_mode != M_LOAD);
    e.cen   = (m_mode == M_RUN);
    e.busy  = (m_mode == M_LOAD) || (m_mode == M_RUN) || (m_mode == M_PAUSE);
    e.done  = (m_mode == M_DONE);
    e.err   = err;
    e.m     = m_min;
    e.t     = m_tens;
    e.o     = m_ones;
    exp_q.push_back(e);
  endtask

  task automatic key(input int code);
    step(1'b1, code, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_loadn"},    {3'b0, o_loadn},       4'd1);
    chk({tag, "_count_en"}, {3'b0, o_count_en},    4'd0);
    chk({tag, "_busy"},     {3'b0, o_busy},        4'd0);
    chk({tag, "_done"},     {3'b0, o_done},        4'd0);
    chk({tag, "_err"},      {3'b0, o_entry_error}, 4'd0);
    chk({tag, "_min"},      o_min_data,            4'd0);
    chk({tag, "_tens"},     o_sec_tens_data,       4'd0);
    chk({tag, "_ones"},     o_sec_ones_data,       4'd0);
  endtask

  // Asynchronous reset between clock edges while the counters are running.
  task automatic reset_mid_run();
    @(negedge clk);
    #2;
    chk("pre_reset_count_en", {3'b0, o_count_en}, 4'd1);
    clrn          = 1'b0;
    i_key_valid   = 1'b0;
    i_timer_zero  = 1'b0;
    i_door_closed = 1'b1;
    #1;
    check_reset("midrun");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2;
    clrn = 1'b1;
  endtask

  initial begin
    cyc           = 0;
    checks        = 0;
    errors        = 0;
    clrn          = 1'b0;
    i_key_valid   = 1'b0;
    i_key_code    = 4'd0;
    i_door_closed = 1'b1;
    i_timer_zero  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");
    #1;
    clrn = 1'b1;

    // 1:30 load, run, complete, then a fresh first digit and CLEAR.
    key(1); key(3); key(0); key(11);
    idle(3);
    step(1'b0, 0, 1'b1, 1'b1);
    idle(2);
    key(5); key(10);

    // Four digits keep the newest three, then CLEAR.
    key(1); key(2); key(3); key(4);
    idle(1);
    key(10);

    // 0:75 is rejected or normalised to 1:15 depending on the build.
    key(7); key(5); key(11);
    idle(2);
    step(1'b0, 0, 1'b1, 1'b1);
    idle(2);
    key(10);

    // Pause on door open, rejected restart with door open, resume without reload.
    key(2); key(0); key(11);
    idle(2);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 11, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    key(11);
    idle(2);
    step(1'b0, 0, 1'b0, 1'b1);
    idle(2);

    // START at 0:00, START with door open, then reset while running.
    key(11);
    key(4);
    step(1'b1, 11, 1'b0, 1'b0);
    key(10);
    key(3); key(0); key(11);
    idle(3);
    reset_mid_run();

    // Random keys, door and timer activity.
    for (int n = 0; n < 3000; n++) begin
      int  r;
      int  code;
      bit  kv;
      bit  door;
      bit  tz;
      r  = int'($urandom_range(0, 99));
      if (r < 60)      code = int'($urandom_range(0, 9));
      else if (r < 75) code = 11;
      else if (r < 85) code = 10;
      else             code = int'($urandom_range(12, 15));
      kv   = ($urandom_range(0, 99) < 35);
      door = ($urandom_range(0, 99) < 92);
      tz   = ($urandom_range(0, 99) < 4);
      step(kv, code, door, tz);
    end

    idle(3);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_entry_loader.md
Name: time_entry_loader

Overview:
Keypad-side writer for the microwave timer digit chain. It collects BCD keypad digits into an M:SS entry and validates it on START. It drives the active-low parallel-load and data lines of the seconds-ones, seconds-tens and minutes down-counters, then gates their count enable until they report zero. It sits between the keypad scanner and the counter chain.

Parameters:
MAX_SEC_TENS, 5, largest legal seconds-tens digit
KEY_W, 4, width of the keypad code bus

Ports:
clk  input  1  system clock
clrn  input  1  reset; asynchronous, active-low
key_valid  input  1  one-cycle strobe; key_code is valid
key_code  input  KEY_W  0-9 digit, 4'hA CLEAR, 4'hB START; 4'hC-4'hF ignored
door_closed  input  1  high = door shut
timer_zero  input  1  AND of all counter zero flags
sec_ones_data  output  4  BCD load/display digit
sec_tens_data  output  4  BCD load/display digit
min_data  output  4  BCD load/display digit
loadn  output  1  active-low parallel load to all counters
count_en  output  1  counter enable
busy  output  1  high in LOAD, RUN, PAUSE
done  output  1  one-cycle pulse on completion
entry_error  output  1  one-cycle pulse on rejected START

Behaviour:
- Reset (clrn low, asynchronous):
  - State is IDLE.
  - All digits are 0.
  - loadn=1, count_en=0, done=0, entry_error=0, busy=0.
- All outputs are registered. Keys are acted on in the cycle key_valid is high.
- States are IDLE, ENTRY, LOAD, RUN, PAUSE and DONE.
- IDLE or ENTRY, digit key:
  - Shift left: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=key.
  - The fourth and later digits discard the oldest digit.
  - State goes to ENTRY.
- IDLE or ENTRY, CLEAR: digits go to 0 and state goes to IDLE.
- IDLE or ENTRY, START. START is rejected, with a one-cycle entry_error pulse and no state or digit change, when any of these holds:
  - door_closed=0
  - all digits are 0
  - sec_tens>MAX_SEC_TENS
  Otherwise the state goes to LOAD.
- LOAD is exactly one cycle.
  - START registered in cycle N gives loadn=0 in cycle N+1.
  - In that cycle, data outputs hold the validated digits.
  - State goes to RUN in N+2.
- RUN:
  - count_en=1 while the state is RUN.
  - timer_zero=1 goes to DONE.
  - door_closed=0 or CLEAR goes to PAUSE; count_en drops on the next cycle.
  - Digit and START keys are ignored.
- PAUSE:
  - count_en=0.
  - START with door_closed=1 goes back to RUN with no reload.
  - START with the door open gives an entry_error pulse.
  - CLEAR goes to IDLE and zeroes the digits.
- DONE: done=1 for one cycle, digits go to 0, then state goes to IDLE.
- Keys arriving during LOAD or DONE are dropped.
- Simultaneous timer_zero and door opening in RUN: DONE has priority.
- timer_zero is ignored outside RUN.
- Reset mid-RUN: count_en drops immediately and the counters are not reloaded.
- Digit values are never greater than 9. Key codes 0-9 only are accepted as digits.

Optional Feature:
AUTO_NORMALIZE_EN
- Defined: on START with sec_tens>MAX_SEC_TENS, the block normalises the entry instead of rejecting it.
  - sec_tens <= sec_tens-(MAX_SEC_TENS+1)
  - min <= min+1
  - Normalised digits appear in cycle N+1 with loadn=0.
  - If min=9, the entry is still rejected with entry_error.
- Undefined: sec_tens>MAX_SEC_TENS is always rejected.

Decomposition:
- Package microwave_pkg holds:
  - key code constants KEY_CLEAR=4'hA and KEY_START=4'hB
  - state enum tel_state_t
  - BCD digit typedef
- Natural sub-module: digit_entry_shifter. It is the 3-digit BCD shift register with clear and the normalise/validate logic. The top module keeps the FSM and the load/enable sequencing.

Test Plan:
1. Press 1,3,0, then START with the door closed → digits 1:30. loadn=0 exactly one cycle, one cycle after START. count_en=1 from the following cycle.
2. Press 1,2,3,4 → displayed digits 2:34, oldest digit dropped. CLEAR → 0:00, state IDLE.
3. Entry 0:75, then START:
   - without AUTO_NORMALIZE_EN → entry_error pulse, loadn stays 1;
   - with it → loads 1:15.
4. RUN, then door_closed=0 → count_en=0 on the next cycle, busy=1. Door closed, then START → count_en=1, no loadn pulse.
5. RUN, then timer_zero=1 → done pulse of one cycle, digits 0, IDLE. A digit key is then accepted as the first entry digit.
6. START at 0:00 or with the door open → entry_error, no loadn. Assert clrn mid-RUN → all outputs at reset values asynchronously.
